// File: rtl/cp0_param.sv
// Coprocessor-0 subset for a single-issue MIPS core: Count/Compare timer, SR, Cause,
// EPC and PrID, with exception/interrupt request generation at the commit point.
module cp0_param #(
    parameter int          NUM_HWINT  = 6,
    parameter logic [31:0] TEXT_START = 32'h0000_3000,
    parameter logic [31:0] PRID       = 32'hbaad_face
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc,
    input  logic                 bd_in,
    input  logic [4:0]           rd,
    input  logic [31:0]          wdata,
    input  logic                 mtc0_en,
    input  logic                 eret_en,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic [4:0]           exc_code,
    output logic                 req,
    output logic [31:0]          epc,
    output logic [31:0]          rdata
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    // Bit 15 of IM/IP is always implemented because the timer shares it.
    function automatic logic [5:0] impl_mask(input int n);
        logic [5:0] m;
        for (int i = 0; i < 6; i++) begin
            m[i] = (i < n) || (i == 5);
        end
        return m;
    endfunction

    localparam logic [5:0] IM_MASK = impl_mask(NUM_HWINT);

    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic [5:0]  ip;
    logic [4:0]  exc_r;
    logic        bd;
    logic [31:0] epc_r;

    logic [5:0]  hw_ext;
    logic [5:0]  ip_next;
    logic        int_pend;
    logic        req_core;
    logic        wr_en;
    logic        timer_hit;
    logic [31:0] pc_sel;
    logic [31:0] epc_target;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    for (genvar g = 0; g < 6; g++) begin : g_hw
        if (g < NUM_HWINT) begin : g_impl
            assign hw_ext[g] = hwint[g];
        end else begin : g_absent
            assign hw_ext[g] = 1'b0;
        end
    end

    assign ip_next   = {hw_ext[5] | timer_pend, hw_ext[4:0]} & IM_MASK;
    assign int_pend  = (|(ip & im)) & ie & ~exl;
    assign req_core  = (int_pend | (exc_code != 5'd0)) & ~exl;
    // State is held in reset, so only the output needs masking.
    assign req       = req_core & ~reset;
    assign wr_en     = mtc0_en & ~req_core;
    assign timer_hit = (count == compare) && (compare != 32'd0);

    assign pc_sel     = bd_in ? (pc - 32'd4) : pc;
    assign epc_target = pc_sel & 32'hFFFF_FFFC;

    assign sr_val    = {16'b0, im, 8'b0, exl, ie};
    assign cause_val = {bd, 15'b0, ip, 3'b0, exc_r, 2'b0};
    assign epc       = epc_r;

    always_comb begin
        rdata = 32'd0;
        case (rd)
            REG_COUNT:   rdata = count;
            REG_COMPARE: rdata = compare;
            REG_SR:      rdata = sr_val;
            REG_CAUSE:   rdata = cause_val;
            REG_EPC:     rdata = epc_r;
            REG_PRID:    rdata = PRID;
            default:     rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= 32'd0;
            compare    <= 32'd0;
            timer_pend <= 1'b0;
        end else begin
            if (wr_en && rd == REG_COUNT) begin
                count <= wdata;
            end else begin
                count <= count + 32'd1;
            end

            // A Compare write clears the pending tick unless it re-arms the very value Count holds.
            if (wr_en && rd == REG_COMPARE) begin
                compare    <= wdata;
                timer_pend <= timer_hit && (wdata == count);
            end else if (timer_hit) begin
                timer_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im    <= IM_MASK;
            exl   <= 1'b0;
            ie    <= 1'b1;
            ip    <= 6'd0;
            exc_r <= 5'd0;
            bd    <= 1'b0;
            epc_r <= TEXT_START;
        end else begin
            ip <= ip_next;
            if (req_core) begin
                exl   <= 1'b1;
                bd    <= bd_in;
                epc_r <= epc_target;
                exc_r <= int_pend ? 5'd0 : exc_code;
            end else begin
                if (wr_en && rd == REG_SR) begin
                    im  <= wdata[15:10] & IM_MASK;
                    exl <= wdata[1];
                    ie  <= wdata[0];
                end else if (eret_en && exl) begin
                    exl <= 1'b0;
                end
                if (wr_en && rd == REG_EPC) begin
                    epc_r <= wdata & 32'hFFFF_FFFC;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_param.sv
// Directed scenarios plus a randomized run of cp0_param, checked every cycle against
// a register-level reference model of the CP0 rules.
module tb_cp0_param;

    localparam logic [31:0] TEXT_START = 32'h0000_3000;
    localparam logic [31:0] PRID       = 32'hbaad_face;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        bd_in;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        mtc0_en;
    logic        eret_en;
    logic [5:0]  hwint;
    logic [4:0]  exc_code;
    logic        req;
    logic [31:0] epc;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    cp0_param #(.NUM_HWINT(6), .TEXT_START(TEXT_START), .PRID(PRID)) dut (
        .clk(clk), .reset(reset), .pc(pc), .bd_in(bd_in), .rd(rd), .wdata(wdata),
        .mtc0_en(mtc0_en), .eret_en(eret_en), .hwint(hwint), .exc_code(exc_code),
        .req(req), .epc(epc), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Reference model state: the architectural fields, one variable each.
    logic [31:0] m_count, m_compare, m_epc;
    logic        m_tp, m_exl, m_ie, m_bd;
    logic [5:0]  m_im, m_ip;
    logic [4:0]  m_exc;

    function automatic logic m_intp();
        return (|(m_ip & m_im)) && m_ie && !m_exl;
    endfunction

    function automatic logic m_req();
        if (reset) return 1'b0;
        return (m_intp() || exc_code != 5'd0) && !m_exl;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] idx);
        case (idx)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return {16'b0, m_im, 8'b0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'b0, m_ip, 3'b0, m_exc, 2'b0};
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_tp = 0;
        m_im = 6'h3F; m_exl = 0; m_ie = 1;
        m_ip = 0; m_exc = 0; m_bd = 0; m_epc = TEXT_START;
    endtask

    task automatic model_step();
        logic        take, intr, wr, hit;
        logic [31:0] target;
        take = m_req();
        intr = m_intp();
        wr   = mtc0_en && !take;
        hit  = (m_count == m_compare) && (m_compare != 0);
        if (wr && rd == 5'd11) m_tp = hit && (wdata == m_count);
        else                   m_tp = m_tp || hit;
        if (wr && rd == 5'd11) m_compare = wdata;
        m_count = (wr && rd == 5'd9) ? wdata : m_count + 1;
        if (take) begin
            target = bd_in ? pc - 4 : pc;
            m_epc  = {target[31:2], 2'b00};
            m_exl  = 1;
            m_bd   = bd_in;
            m_exc  = intr ? 5'd0 : exc_code;
        end else begin
            if (wr && rd == 5'd12) begin
                m_im = wdata[15:10]; m_exl = wdata[1]; m_ie = wdata[0];
            end else if (eret_en && m_exl) begin
                m_exl = 0;
            end
            if (wr && rd == 5'd14) m_epc = {wdata[31:2], 2'b00};
        end
    endtask

    // The timer pending bit lands in IP one edge after it is raised, so IP uses the pre-step value.
    task automatic model_edge();
        logic [5:0] nip;
        nip = {hwint[5] | m_tp, hwint[4:0]};
        if (reset) model_reset();
        else begin
            model_step();
            m_ip = nip;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        #1;
        chk("req", {31'd0, req}, {31'd0, m_req()});
        chk("epc", epc, m_epc);
        chk("rdata", rdata, m_rdata(rd));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        rd = idx;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] val);
        mtc0_en = 1; rd = idx; wdata = val;
        tick();
        mtc0_en = 0;
    endtask

    task automatic eret();
        eret_en = 1;
        tick();
        eret_en = 0;
    endtask

    logic [4:0]  rd_tab [8] = '{5'd0, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd1};
    logic [31:0] r;

    initial begin
        reset = 1; pc = 0; bd_in = 0; rd = 0; wdata = 0;
        mtc0_en = 0; eret_en = 0; hwint = 6'h3F; exc_code = 5'd5;
        model_reset();
        #1;
        chk("reset_req", {31'd0, req}, 32'd0);
        chk("reset_epc", epc, TEXT_START);
        rd_chk("reset_sr", 5'd12, 32'h0000_FC01);
        rd_chk("reset_cause", 5'd13, 32'h0000_0000);
        tick(); tick();
        hwint = 0; exc_code = 0;
        tick();
        reset = 0;

        // Scenario 1: post-reset register values
        rd_chk("s1_sr", 5'd12, 32'h0000_FC01);
        rd_chk("s1_cause", 5'd13, 32'h0000_0000);
        rd_chk("s1_epc", 5'd14, 32'h0000_3000);
        rd_chk("s1_prid", 5'd15, 32'hbaad_face);
        rd_chk("s1_unimpl", 5'd3, 32'h0000_0000);

        // Scenario 2: hardware interrupt line 2
        hwint = 6'b000100; pc = 32'h3010; bd_in = 0;
        tick();
        chk("s2_req_set", {31'd0, req}, 32'd1);
        tick();
        rd_chk("s2_cause", 5'd13, 32'h0000_1000);
        rd_chk("s2_epc", 5'd14, 32'h0000_3010);
        rd_chk("s2_sr", 5'd12, 32'h0000_FC03);
        chk("s2_req_exl", {31'd0, req}, 32'd0);
        hwint = 0;
        tick();
        eret();

        // Scenario 3: synchronous exception in a delay slot
        exc_code = 5'd12; pc = 32'h3024; bd_in = 1;
        #1;
        chk("s3_req", {31'd0, req}, 32'd1);
        tick();
        exc_code = 0; bd_in = 0;
        rd_chk("s3_cause", 5'd13, 32'h8000_0030);
        rd_chk("s3_epcreg", 5'd14, 32'h0000_3020);
        eret();
        rd_chk("s3_sr", 5'd12, 32'h0000_FC01);
        chk("s3_epc", epc, 32'h0000_3020);

        // Scenario 4: interrupt beats exception, MTC0 discarded
        hwint = 6'b000010; pc = 32'h3040;
        tick();
        exc_code = 5'd10; mtc0_en = 1; rd = 5'd12; wdata = 32'd0;
        #1;
        chk("s4_req", {31'd0, req}, 32'd1);
        tick();
        mtc0_en = 0; exc_code = 0;
        rd_chk("s4_cause", 5'd13, 32'h0000_0800);
        rd_chk("s4_sr", 5'd12, 32'h0000_FC03);
        hwint = 0;
        tick();
        eret();

        // Scenario 5: timer and Count wrap
        mtc0(5'd12, 32'h0000_FC00);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd5);
        rd = 5'd13;
        repeat (5) tick();
        chk("s5_ip15_early", {31'd0, rdata[15]}, 32'd0);
        tick();
        chk("s5_ip15_set", {31'd0, rdata[15]}, 32'd1);
        mtc0(5'd11, 32'd100);
        rd = 5'd13;
        tick();
        chk("s5_ip15_clr", {31'd0, rdata[15]}, 32'd0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd_chk("s5_count_max", 5'd9, 32'hFFFF_FFFF);
        tick();
        rd_chk("s5_count_wrap", 5'd9, 32'h0000_0000);
        mtc0(5'd11, 32'd0);

        // Scenario 6: IE gates the interrupt
        mtc0(5'd12, 32'h0000_0400);
        hwint = 6'b000001; pc = 32'h3100;
        tick(); tick();
        chk("s6_no_req", {31'd0, req}, 32'd0);
        mtc0(5'd12, 32'h0000_0401);
        #1;
        chk("s6_req", {31'd0, req}, 32'd1);
        tick();
        hwint = 0;
        tick();
        eret();
        mtc0(5'd12, 32'h0000_FC01);

        // Reset while inside a handler
        exc_code = 5'd8; pc = 32'h3200;
        tick();
        exc_code = 5'd3;
        rd_chk("mid_sr", 5'd12, 32'h0000_FC03);
        #2;
        reset = 1;
        model_reset();
        #1;
        chk("mid_req", {31'd0, req}, 32'd0);
        chk("mid_epc", epc, TEXT_START);
        rd_chk("mid_sr_rst", 5'd12, 32'h0000_FC01);
        rd_chk("mid_cause_rst", 5'd13, 32'h0000_0000);
        tick();
        exc_code = 0;
        reset = 0;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            hwint = (r[2:0] == 3'd0) ? r[13:8] : 6'd0;
            exc_code = (r[7:4] == 4'd0) ? r[20:16] : 5'd0;
            bd_in = r[21];
            rd = rd_tab[r[24:22]];
            mtc0_en = (r[26:25] == 2'd0);
            eret_en = !mtc0_en && (r[29:27] == 3'd0);
            r = $urandom;
            pc = r;
            wdata = (rd == 5'd11) ? m_count + {29'd0, r[2:0]} : $urandom;
            tick();
        end
        mtc0_en = 0; eret_en = 0; hwint = 0; exc_code = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
